arb_rr_4x8: RTL and testbench

ARB_RR_4X8 -- requirements
Module: arb_rr_4x8

---
 rtl/arb_rr_4x8.sv | 76 +++++++
 tb/tb_arb_rr_4x8.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/arb_rr_4x8.sv
// Round-robin arbiter over four byte channels feeding a one-deep output register.
// The winner's byte arrives combinationally through an external 4:1 mux steered by key.
module arb_rr_4x8 #(
   parameter logic [1:0] RESET_PTR = 2'd3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] in_valid,
   input  logic [7:0] mux_out,
   output logic [1:0] key,
   output logic [3:0] grant,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] xfer_count
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t     state, state_nxt;
   logic [1:0] ptr;
   logic [1:0] win;
   logic [1:0] idx;
   logic       found;
   logic       slot_free;
   logic       capture;

   assign out_valid = (state == FULL);
   assign slot_free = !out_valid || out_ready;
   // Reset gates capture so grant stays quiet and key shows ptr while rst_n is low.
   assign capture   = rst_n && slot_free && (in_valid != 4'b0000);

   // Cyclic search starting just after the last granted channel.
   always_comb begin
      win   = ptr;
      found = 1'b0;
      idx   = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         idx = ptr + 2'(i);
         if (!found && in_valid[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   assign key   = capture ? win : ptr;
   assign grant = capture ? (4'b0001 << win) : 4'b0000;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: if (capture) state_nxt = FULL;
         FULL:  if (!capture && out_ready) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data   <= 8'h00;
         ptr        <= RESET_PTR;
         xfer_count <= 8'h00;
      end else if (capture) begin
         out_data   <= mux_out;
         ptr        <= win;
         xfer_count <= xfer_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_arb_rr_4x8.sv
// Directed checks for arb_rr_4x8 followed by a randomized scoreboard/fairness run.
module tb_arb_rr_4x8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] in_valid;
   logic [7:0] mux_out;
   logic [1:0] key;
   logic [3:0] grant;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] xfer_count;

   logic [7:0] tab [4];
   int passed = 0;
   int total  = 0;

   assign mux_out = tab[key];

   always #5 clk = ~clk;

   arb_rr_4x8 dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mux_out(mux_out),
      .key(key), .grant(grant), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .xfer_count(xfer_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0]  q [$];
      logic [7:0]  exp_d;
      logic [7:0]  cnt;
      int          wait_c [4];
      logic [3:0]  ch;

      for (int i = 0; i < 4; i++) tab[i] = 8'h10 + 8'(i);
      rst_n = 1'b0; in_valid = 4'b1111; out_ready = 1'b0;
      #1;
      chk("rst_grant", 32'(grant), 32'h0);
      tick();
      tick();
      chk("rst_key", 32'(key), 32'd3);
      chk("rst_grant2", 32'(grant), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_data", 32'(out_data), 32'h0);
      chk("rst_count", 32'(xfer_count), 32'h0);

      // Full request, consumer always ready: 0,1,2,3,0
      rst_n = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("rr_grant", 32'(grant), 32'(4'b0001 << (k % 4)));
         chk("rr_key", 32'(key), 32'(k % 4));
         tick();
         chk("rr_data", 32'(out_data), 32'h10 + 32'(k % 4));
         chk("rr_valid", 32'(out_valid), 32'h1);
         chk("rr_count", 32'(xfer_count), 32'(k + 1));
      end

      // Drain, then a stalled capture on channel 2
      in_valid = 4'b0000; out_ready = 1'b1;
      tick();
      chk("drain_valid", 32'(out_valid), 32'h0);
      in_valid = 4'b0100; out_ready = 1'b0;
      #1;
      chk("stall_key", 32'(key), 32'd2);
      chk("stall_grant", 32'(grant), 32'b0100);
      tick();
      for (int k = 0; k < 10; k++) begin
         chk("stall_g0", 32'(grant), 32'h0);
         chk("stall_data", 32'(out_data), 32'h12);
         chk("stall_valid", 32'(out_valid), 32'h1);
         tick();
      end
      chk("stall_count", 32'(xfer_count), 32'd6);
      in_valid = 4'b0000; out_ready = 1'b1;
      tick();
      chk("release_valid", 32'(out_valid), 32'h0);
      chk("release_count", 32'(xfer_count), 32'd6);

      // Park ptr on 1, then contend 0 and 1
      in_valid = 4'b0010;
      #1;
      chk("ptr1_grant", 32'(grant), 32'b0010);
      tick();
      in_valid = 4'b0011;
      #1;
      chk("wrap_grant0", 32'(grant), 32'b0001);
      chk("wrap_key0", 32'(key), 32'd0);
      tick();
      chk("wrap_data0", 32'(out_data), 32'h10);
      #1;
      chk("wrap_grant1", 32'(grant), 32'b0010);
      tick();
      chk("wrap_data1", 32'(out_data), 32'h11);
      chk("wrap_count", 32'(xfer_count), 32'd9);

      // Counter wrap
      in_valid = 4'b1111;
      for (int k = 0; k < 246; k++) tick();
      chk("cnt_ff", 32'(xfer_count), 32'hFF);
      tick();
      chk("cnt_wrap", 32'(xfer_count), 32'h00);

      // Reset with a held byte
      for (int i = 0; i < 4; i++) tab[i] = 8'hA5;
      in_valid = 4'b0001;
      tick();
      chk("pre_data", 32'(out_data), 32'hA5);
      chk("pre_valid", 32'(out_valid), 32'h1);
      out_ready = 1'b0; rst_n = 1'b0; in_valid = 4'b1111;
      #1;
      chk("midrst_grant", 32'(grant), 32'h0);
      chk("midrst_key", 32'(key), 32'd0);
      tick();
      chk("midrst_valid", 32'(out_valid), 32'h0);
      chk("midrst_data", 32'(out_data), 32'h00);
      chk("midrst_count", 32'(xfer_count), 32'h00);
      chk("midrst_key2", 32'(key), 32'd3);
      chk("midrst_grant2", 32'(grant), 32'h0);

      // Random traffic against a byte queue and fairness counters
      rst_n = 1'b1; in_valid = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         tab[i] = 8'($urandom);
         wait_c[i] = 0;
      end
      cnt = 8'h00;
      for (int c = 0; c < 10000; c++) begin
         // channels tend to keep requesting once raised
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 9) == 0) in_valid[i] = ~in_valid[i];
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (grant != 4'b0000 && (grant & (grant - 4'd1)) != 4'b0000)
            chk("rnd_onehot", 32'(grant), 32'(4'b0001 << key));
         if (grant != 4'b0000) chk("rnd_key", 32'(grant), 32'(4'b0001 << key));
         if (out_valid != (q.size() != 0)) chk("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
         if (out_valid && out_ready && q.size() != 0) begin
            exp_d = q.pop_front();
            if (out_data !== exp_d) chk("rnd_data", 32'(out_data), 32'(exp_d));
         end
         // grant is expected exactly when there is room and a request
         ch = ((q.size() == 0 || out_ready) && in_valid != 4'b0000) ? 4'b1 : 4'b0;
         if ((grant != 4'b0000) != ch[0]) chk("rnd_capture", 32'(grant != 4'b0000), 32'(ch[0]));
         if (grant != 4'b0000) begin
            q.push_back(tab[key]);
            cnt = cnt + 8'd1;
            for (int i = 0; i < 4; i++) begin
               if (!in_valid[i] || grant[i]) wait_c[i] = 0;
               else wait_c[i]++;
               if (wait_c[i] > 3) chk("rnd_fair", 32'(wait_c[i]), 32'd3);
            end
         end else begin
            for (int i = 0; i < 4; i++) if (!in_valid[i]) wait_c[i] = 0;
         end
         ch = grant;
         tick();
         for (int i = 0; i < 4; i++) if (ch[i]) tab[i] = 8'($urandom);
         if (xfer_count !== cnt) chk("rnd_count", 32'(xfer_count), 32'(cnt));
      end
      chk("rnd_final_count", 32'(xfer_count), 32'(cnt));
      chk("rnd_final_valid", 32'(out_valid), 32'(q.size() != 0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
